axi_sub_rw_arb: RTL
===================

# axi_sub_rw_arb

Arbiter that shares one component register/memory port between the AXI write subordinate (write COMPONENT INF) and the AXI read subordinate (read COMPONENT INF). Grants are burst-atomic: once a side's first beat is accepted, the port stays locked to that side until its `last` beat is accepted. Ties between bursts are broken round-robin. Sits between the write/read subordinates and a single-ported component, such as a register block or SRAM wrapper.

## Interface
Parameters:
- AW, 32, byte address width
- DW, 32, data width
- BC, DW/8, byte count, derived
- UW, 32, user width
- IW, 1, ID width

Ports:
- clk  input  1  clock
- rst_n  input  1  asynchronous active-low reset
- w_dv, w_last  input  1 each  write-side beat valid / final beat of burst
- w_addr, w_user, w_id  input  AW, UW, IW  write-side address / user / ID
- w_wdata, w_wstrb  input  DW, BC  write-side data / strobes
- w_hld, w_err  output  1 each  stall / error returned to write side
- r_dv, r_last  input  1 each  read-side beat valid / final beat of burst
- r_addr, r_user, r_id  input  AW, UW, IW  read-side address / user / ID
- r_rdata  output  DW  read data to read side
- r_hld, r_err  output  1 each  stall / error returned to read side
- dv, write, last  output  1 each  component beat valid / 1 = write / final beat
- addr, user, id  output  AW, UW, IW  component address / user / ID
- wdata, wstrb  output  DW, BC  component write data / strobes (zero on reads)
- hld, err  input  1 each  component stall / error, same cycle as dv
- rdata  input  DW  component read data, valid in the cycle dv && !hld && !write

## Operation
- State register `st` takes one of: IDLE, LOCK_WR, LOCK_RD. Flop `pri` names the side that wins the next tie (WR or RD).
- Grant selection:
  - LOCK_WR → write side. LOCK_RD → read side.
  - IDLE, only one dv high → that side.
  - IDLE, both dv high → side named by `pri`.
  - IDLE, neither dv high → no grant.
- Component outputs take the granted side's fields. With no grant: dv = 0 and the fields follow the write side.
- write = 1 when write is granted.
- last = granted side's last. wdata/wstrb are forced to 0 on a read grant.
- Granted side: hld = component hld; err = component err when its beat is accepted.
- Non-granted side: hld = 1 whenever its dv is high, otherwise 0; err = 0.
- r_rdata = rdata, passed through unconditionally.
- Beat accepted = dv && !hld.
- Transitions on an accepted beat:
  - Granted side's last = 0 → `st` becomes LOCK_<side>.
  - Granted side's last = 1 → `st` becomes IDLE and `pri` becomes the opposite side.
- A single-beat burst granted from IDLE leaves `st` at IDLE and toggles `pri`.
- While locked, the other side is starved even if the locked side deasserts dv. No mid-burst switching, because the write side's exclusive-clear and the read side's ordering depend on contiguous bursts.
- The arbiter never drops or duplicates a beat. It never asserts dv without an input dv.

## Timing
- Zero-cycle latency: all component outputs, hld and err are combinational from inputs plus `st`.
- No bubble between bursts. The beat after a `last` may be granted in the next cycle.
- Reset (async assert, sync deassert from the system):
  - st = IDLE, pri = WR.
  - Outputs then reflect inputs combinationally: dv = 0 when w_dv = r_dv = 0, and w_hld = r_hld = 0.
- Reset mid-burst abandons the lock. Both subordinates are reset on the same rst_n.
- Simultaneous events:
  - Both sides present a first beat in IDLE → `pri` wins; the loser sees hld = 1 the same cycle.
  - Accepted `last` while the other side is waiting → the other side wins the following cycle regardless of `pri`, because it is the only requester or is favored by `pri`.
- Component hld stalls do not change `st` or `pri`.

## Structure
- Enum `axi_sub_arb_st_e` {IDLE, LOCK_WR, LOCK_RD} belongs in axi_pkg alongside axi_ctx_t.
- No sub-module. The two-way round-robin plus lock fits in one always_ff and one always_comb mux.
- Assertions:
  - Known-value checks on dv, hld and the grants.
  - At most one grant per cycle.
  - No grant change in LOCK_* until an accepted last.
  - dv implies (w_dv || r_dv).

## Test plan
- Reset, then w_dv = 1, r_dv = 0, single beat, last = 1, addr 0x100 → dv = 1, write = 1, addr = 0x100, w_hld = 0; after the cycle pri = RD, st = IDLE.
- Both sides request single beats every cycle from reset → grants alternate W, R, W, R; the loser's hld = 1 each cycle.
- Write burst of 4 (last on beat 4) with r_dv held high from beat 2 → r_hld = 1 for 3 cycles; read is granted on cycle 5.
- Component hld = 1 for 2 cycles mid-read-burst → r_hld follows; st stays LOCK_RD; w_hld = 1 throughout.
- err = 1 on a write beat → w_err = 1 and r_err = 0. Read beat with rdata 0xDEADBEEF → r_rdata = 0xDEADBEEF and wdata = 0.
- rst_n asserted mid write burst (beat 2 of 4) → st = IDLE and pri = WR immediately; after release, a read-only request is granted with zero delay.

Source files
------------

// File: rtl/axi_pkg.sv
// Shared AXI subordinate types: beat context and the read/write arbiter state encodings.
package axi_pkg;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] user;
    logic [0:0]  id;
  } axi_ctx_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    LOCK_WR = 2'd1,
    LOCK_RD = 2'd2
  } axi_sub_arb_st_e;

  typedef enum logic {
    WR = 1'b0,
    RD = 1'b1
  } axi_sub_arb_side_e;

endpackage

// File: rtl/axi_sub_rw_arb.sv
// Burst-atomic round-robin arbiter sharing one component port between the AXI
// write and read subordinates; zero-latency combinational datapath.
module axi_sub_rw_arb
  import axi_pkg::*;
#(
  parameter int AW = 32,
  parameter int DW = 32,
  parameter int BC = DW / 8,
  parameter int UW = 32,
  parameter int IW = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          w_dv,
  input  logic          w_last,
  input  logic [AW-1:0] w_addr,
  input  logic [UW-1:0] w_user,
  input  logic [IW-1:0] w_id,
  input  logic [DW-1:0] w_wdata,
  input  logic [BC-1:0] w_wstrb,
  output logic          w_hld,
  output logic          w_err,
  input  logic          r_dv,
  input  logic          r_last,
  input  logic [AW-1:0] r_addr,
  input  logic [UW-1:0] r_user,
  input  logic [IW-1:0] r_id,
  output logic [DW-1:0] r_rdata,
  output logic          r_hld,
  output logic          r_err,
  output logic          dv,
  output logic          write,
  output logic          last,
  output logic [AW-1:0] addr,
  output logic [UW-1:0] user,
  output logic [IW-1:0] id,
  output logic [DW-1:0] wdata,
  output logic [BC-1:0] wstrb,
  input  logic          hld,
  input  logic          err,
  input  logic [DW-1:0] rdata
);

  axi_sub_arb_st_e   st;
  axi_sub_arb_side_e pri;
  logic              gnt_w;
  logic              gnt_r;
  logic              accepted;

  // Grant: lock wins, then sole requester, then the round-robin pointer.
  always_comb begin
    gnt_w = 1'b0;
    gnt_r = 1'b0;
    case (st)
      LOCK_WR: gnt_w = 1'b1;
      LOCK_RD: gnt_r = 1'b1;
      default: begin
        if (w_dv && r_dv) begin
          gnt_w = (pri == WR);
          gnt_r = (pri == RD);
        end else begin
          gnt_w = w_dv;
          gnt_r = r_dv;
        end
      end
    endcase
  end

  always_comb begin
    dv      = 1'b0;
    write   = gnt_w;
    last    = w_last;
    addr    = w_addr;
    user    = w_user;
    id      = w_id;
    wdata   = w_wdata;
    wstrb   = w_wstrb;
    w_hld   = w_dv;
    r_hld   = r_dv;
    w_err   = 1'b0;
    r_err   = 1'b0;
    r_rdata = rdata;
    if (gnt_w) begin
      dv    = w_dv;
      w_hld = hld;
      w_err = w_dv && !hld && err;
    end else if (gnt_r) begin
      dv    = r_dv;
      last  = r_last;
      addr  = r_addr;
      user  = r_user;
      id    = r_id;
      wdata = '0;
      wstrb = '0;
      r_hld = hld;
      r_err = r_dv && !hld && err;
    end
  end

  assign accepted = dv && !hld;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st  <= IDLE;
      pri <= WR;
    end else if (accepted) begin
      if (last) begin
        st <= IDLE;
        if (gnt_w) pri <= RD;
        else       pri <= WR;
      end else if (gnt_w) begin
        st <= LOCK_WR;
      end else begin
        st <= LOCK_RD;
      end
    end
  end

  a_known: assert property (@(posedge clk) disable iff (!rst_n)
    !$isunknown({dv, hld, gnt_w, gnt_r}));
  a_one_gnt: assert property (@(posedge clk) disable iff (!rst_n)
    !(gnt_w && gnt_r));
  a_lock_wr: assert property (@(posedge clk) disable iff (!rst_n)
    (st == LOCK_WR) |-> (gnt_w && !gnt_r));
  a_lock_rd: assert property (@(posedge clk) disable iff (!rst_n)
    (st == LOCK_RD) |-> (gnt_r && !gnt_w));
  a_dv_src: assert property (@(posedge clk) disable iff (!rst_n)
    dv |-> (w_dv || r_dv));

endmodule
